// File: rtl/sum_sq_pkg.sv
// sum_sq_pkg: shared state encoding and constants for the sum-of-squares unit
package sum_sq_pkg;
    localparam int          N_W     = 8;
    localparam int          ITER    = N_W;
    localparam logic [15:0] SAT_VAL = 16'hFFFF;
    typedef enum logic [1:0] {IDLE = 2'd0, SQ_A = 2'd1, SQ_B = 2'd2, FIN = 2'd3} state_e;
endpackage

// File: rtl/shift_add_sq.sv
// shift_add_sq: one shift-add squaring step; adds op << idx to acc when op[idx] is set
//   op_i  : operand being squared (acts as both multiplicand and multiplier)
//   idx_i : multiplier bit index for this step
//   acc_i : running accumulator
//   acc_o : accumulator after this step
module shift_add_sq #(
    parameter int N = 8
) (
    input  logic [N-1:0]         op_i,
    input  logic [$clog2(N)-1:0] idx_i,
    input  logic [2*N:0]         acc_i,
    output logic [2*N:0]         acc_o
);
    logic [2*N:0] op_ext;
    assign op_ext = {{(N+1){1'b0}}, op_i};
    assign acc_o  = op_i[idx_i] ? acc_i + (op_ext << idx_i) : acc_i;
endmodule

// File: rtl/sum_sq.sv
// sum_sq: sequential a*a + b*b with 16-bit saturation and start/ready/busy handshake
//   clk, rst (sync, active-low)
//   start, a_b, b_b : request and operands, taken when ready
//   ready, busy     : idle / computing
//   y_b, ovf, valid : saturated result, overflow flag, one-cycle result strobe
module sum_sq
    import sum_sq_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a_b,
    input  logic [N-1:0]   b_b,
    output logic           ready,
    output logic           busy,
    output logic [2*N-1:0] y_b,
    output logic           ovf,
    output logic           valid
);
    localparam int CW = $clog2(N);
    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N:0]   acc_q, acc_d, acc_step;
    logic [2*N-1:0] y_q, y_d;
    logic           ovf_q, ovf_d, valid_q, valid_d;
    logic           last;

    // A single step unit serves both squares; the operand mux picks b during SQ_B.
    shift_add_sq #(.N(N)) u_step (
        .op_i  (state_q == SQ_B ? b_q : a_q),
        .idx_i (cnt_q),
        .acc_i (acc_q),
        .acc_o (acc_step)
    );

    assign last = cnt_q == CW'(ITER - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a_b;
                b_d     = b_b;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = SQ_A;
            end
            SQ_A: begin
                acc_d   = acc_step;
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                state_d = last ? SQ_B : SQ_A;
            end
            SQ_B: begin
                acc_d   = acc_step;
                cnt_d   = last ? '0 : cnt_q + CW'(1);
                state_d = last ? FIN : SQ_B;
            end
            FIN: begin
                // acc[2N] marks a true sum above the 2N-bit range
                y_d     = acc_q[2*N] ? SAT_VAL : acc_q[2*N-1:0];
                ovf_d   = acc_q[2*N];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign ready = state_q == IDLE;
    assign busy  = ~ready;
    assign y_b   = y_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_sum_sq.sv
// tb_sum_sq: table-driven, hand-sequenced and randomized checks of sum_sq against a plain-arithmetic model
module tb_sum_sq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a_b = '0, b_b = '0;
    logic        ready, busy, ovf, valid;
    logic [15:0] y_b;
    int          checks = 0, errors = 0;

    sum_sq #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_b(a_b), .b_b(b_b),
        .ready(ready), .busy(busy), .y_b(y_b), .ovf(ovf), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a, b;
        logic [15:0] y;
        logic        o;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) * int'(a) + int'(b) * int'(b);
        return s > 65535 ? {1'b1, 16'hFFFF} : {1'b0, 16'(s)};
    endfunction

    // Issue one request and wait for its result; poke>0 pulses start with (9,9) at that busy cycle.
    task automatic run(input logic [7:0] a, input logic [7:0] b, input int poke, output int lat, output int rdy_hi);
        @(negedge clk);
        start = 1'b1; a_b = a; b_b = b;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        lat = 0;
        rdy_hi = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == poke) begin start = 1'b1; a_b = 8'd9; b_b = 8'd9; end
            @(negedge clk);
            start = 1'b0;
            if (valid) begin lat = i; break; end
            if (ready) rdy_hi++;
        end
    endtask

    task automatic run_check(input string nm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] ey, input logic eo, input int poke);
        int lat, rh;
        run(a, b, poke, lat, rh);
        chk({nm, "_latency"}, lat, 17);
        chk({nm, "_ready_low"}, rh, 0);
        chk({nm, "_y"}, y_b, ey);
        chk({nm, "_ovf"}, ovf, eo);
        chk({nm, "_ready_at_valid"}, ready, 1);
        @(negedge clk);
        chk({nm, "_valid_drop"}, valid, 0);
        chk({nm, "_y_hold"}, y_b, ey);
    endtask

    task automatic quiet(input string nm, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk({nm, "_no_valid"}, pulses, 0);
    endtask

    vec_t vt[8];

    initial begin
        int lat, rh;
        logic [16:0] m;
        vt[0] = '{8'd3,   8'd4,   16'd25,    1'b0};
        vt[1] = '{8'd255, 8'd22,  16'hFFE5,  1'b0};
        vt[2] = '{8'd255, 8'd23,  16'hFFFF,  1'b1};
        vt[3] = '{8'd255, 8'd255, 16'hFFFF,  1'b1};
        vt[4] = '{8'd6,   8'd8,   16'd100,   1'b0};
        vt[5] = '{8'd181, 8'd181, 16'd65522, 1'b0};
        vt[6] = '{8'd1,   8'd1,   16'd2,     1'b0};
        vt[7] = '{8'd0,   8'd255, 16'd65025, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_y", y_b, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid", valid, 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].y, vt[i].o, 0);

        // start during busy is dropped, no extra result
        run_check("ignore", 8'd0, 8'd0, 16'd0, 1'b0, 5);
        quiet("ignore", 20);
        chk("ignore_y", y_b, 0);

        // start held high: two results 18 clocks apart
        @(negedge clk);
        start = 1'b1; a_b = 8'd1; b_b = 8'd1;
        @(negedge clk);
        a_b = 8'd181; b_b = 8'd181;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid) begin lat = i; break; end
        end
        chk("b2b_first_latency", lat, 17);
        chk("b2b_first_y", y_b, 2);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid) begin lat = i; break; end
        end
        start = 1'b0;
        chk("b2b_spacing", lat, 18);
        chk("b2b_second_y", y_b, 65522);
        quiet("b2b", 20);

        // reset mid-operation
        run_check("pre_abort", 8'd255, 8'd255, 16'hFFFF, 1'b1, 0);
        @(negedge clk);
        start = 1'b1; a_b = 8'd3; b_b = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_y", y_b, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);
        rst = 1'b1;
        quiet("abort", 20);
        run_check("post_abort", 8'd6, 8'd8, 16'd100, 1'b0, 0);

        // randomized against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i < 5) ra = 8'($urandom_range(200, 255));
            m = model(ra, rb);
            run(ra, rb, 0, lat, rh);
            chk($sformatf("rnd%0d_latency", i), lat, 17);
            chk($sformatf("rnd%0d_y(%0d,%0d)", i, ra, rb), y_b, m[15:0]);
            chk($sformatf("rnd%0d_ovf", i), ovf, m[16]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
